// File: rtl/mod_dds_seq_pkg.sv
// Shared types and command-word layout for the modulated-DDS sequencer.
// Field positions above the address depend on the address width, so they are functions.
package mod_dds_seq_pkg;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam int ADDR_LSB    = 0;
   localparam int NSAMP_W     = 16;
   localparam int MEM_LAT_MIN = 1;
   localparam int MEM_LAT_MAX = 8;

   function automatic int nsamp_lsb(input int aw);
      return aw;
   endfunction

   function automatic int sync_bit(input int aw);
      return aw + NSAMP_W;
   endfunction

   function automatic bit mem_lat_ok(input int lat);
      return (lat >= MEM_LAT_MIN) && (lat <= MEM_LAT_MAX);
   endfunction

endpackage

// File: rtl/mod_dds_seq_if.sv
// AXI-Stream command channel into the DDS sequencer.
interface mod_dds_seq_if #(parameter int AW = 8);
   import mod_dds_seq_pkg::*;

   logic [AW+NSAMP_W:0] tdata;
   logic                tvalid;
   logic                tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/mod_dds_seq_dly.sv
// Fixed-depth shift register that matches the parameter-memory read latency.
// vld_any reports whether any stage still carries a valid sample.
module seq_dly #(
   parameter int W       = 11,
   parameter int DEPTH   = 2,
   parameter int VLD_BIT = 2
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic [W-1:0] d,
   output logic [W-1:0] q,
   output logic         vld_any
);

   logic [W-1:0] stg [DEPTH];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) stg[i] <= '0;
      end else begin
         stg[0] <= d;
         for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
      end
   end

   assign q = stg[DEPTH-1];

   always_comb begin
      vld_any = 1'b0;
      for (int i = 0; i < DEPTH; i++) vld_any = vld_any | stg[i][VLD_BIT];
   end

endmodule

// File: rtl/mod_dds_seq.sv
// Command sequencer for the modulated-DDS channel: issues the parameter address and a
// time base whose valid/sync/last qualifiers are delayed to line up with mem_dout.
module mod_dds_seq
   import mod_dds_seq_pkg::*;
#(
   parameter int AW      = 8,
   parameter int BT      = 8,
   parameter int MEM_LAT = 2
) (
   input  logic          clk,
   input  logic          rstn,
   mod_dds_seq_if.slave  s_axis,
   input  logic          abort,
   output logic [AW-1:0] mem_addr,
   output logic [BT-1:0] t_out,
   output logic          t_valid,
   output logic          sync_out,
   output logic          busy,
   output logic          done
);

   localparam int NL = nsamp_lsb(AW);
   localparam int SB = sync_bit(AW);
   localparam int PW = BT + 3;

   if (!mem_lat_ok(MEM_LAT)) begin : g_bad_mem_lat
      $error("mod_dds_seq: MEM_LAT must be within 1..8");
   end

   state_t               state;
   logic [NSAMP_W-1:0]   cnt;
   logic [BT-1:0]        t_raw;
   logic [BT-1:0]        t_hold;
   logic                 sync_r;

   logic [AW-1:0]        cmd_addr;
   logic [NSAMP_W-1:0]   cmd_nsamp;
   logic                 cmd_sync;
   logic                 run, last_cyc, accept, load;

   logic                 vld_p0, sync_p0, last_p0;
   logic [BT-1:0]        t_p0;
   logic [PW-1:0]        pipe_q;
   logic                 pipe_vld;

   function automatic logic [BT-1:0] sat_inc(input logic [BT-1:0] v);
      if (&v) return v;
      return v + BT'(1);
   endfunction

   assign cmd_addr  = s_axis.tdata[ADDR_LSB +: AW];
   assign cmd_nsamp = s_axis.tdata[NL +: NSAMP_W];
   assign cmd_sync  = s_axis.tdata[SB];

   assign run       = (state == RUN);
   assign last_cyc  = run && (cnt == NSAMP_W'(1));
   assign s_axis.tready = rstn & ~abort & (~run | last_cyc);
   assign accept    = s_axis.tvalid & s_axis.tready;
   // A zero-length command is consumed here but never loads the counters.
   assign load      = accept && (cmd_nsamp != '0);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         cnt      <= '0;
         t_raw    <= '0;
         t_hold   <= '0;
         sync_r   <= 1'b0;
         mem_addr <= '0;
      end else begin
         if (vld_p0) t_hold <= t_raw;
         if (load) begin
            state    <= RUN;
            mem_addr <= cmd_addr;
            t_raw    <= '0;
            cnt      <= cmd_nsamp;
            sync_r   <= cmd_sync;
         end else if (run) begin
            if (abort || last_cyc) begin
               state <= IDLE;
            end else begin
               cnt    <= cnt - NSAMP_W'(1);
               t_raw  <= sat_inc(t_raw);
               sync_r <= 1'b0;
            end
         end
      end
   end

   // p0: raw sample stage; the sample on which abort is seen is withheld
   assign vld_p0  = run & ~abort;
   assign sync_p0 = sync_r & vld_p0;
   assign last_p0 = last_cyc & ~abort;
   assign t_p0    = vld_p0 ? t_raw : t_hold;

   seq_dly #(
      .W       (PW),
      .DEPTH   (MEM_LAT),
      .VLD_BIT (2)
   ) u_dly (
      .clk     (clk),
      .rstn    (rstn),
      .d       ({t_p0, vld_p0, sync_p0, last_p0}),
      .q       (pipe_q),
      .vld_any (pipe_vld)
   );

   // p(MEM_LAT): aligned with mem_dout
   assign {t_out, t_valid, sync_out, done} = pipe_q;
   assign busy = run | pipe_vld;

endmodule

// File: tb/tb_mod_dds_seq.sv
// Directed bench for mod_dds_seq: per-cycle vector table plus saturation and async-reset sequences.
module tb_mod_dds_seq;

   logic clk = 1'b0;
   logic rstn;
   logic abort_a, abort_b;

   logic [7:0] addr_a, t_a, addr_b;
   logic [3:0] t_b;
   logic       tv_a, sy_a, bz_a, dn_a;
   logic       tv_b, sy_b, bz_b, dn_b;

   int errs   = 0;
   int checks = 0;

   mod_dds_seq_if #(.AW(8)) ifa ();
   mod_dds_seq_if #(.AW(8)) ifb ();

   always #5 clk = ~clk;

   mod_dds_seq #(.AW(8), .BT(8), .MEM_LAT(2)) dut_a (
      .clk(clk), .rstn(rstn), .s_axis(ifa), .abort(abort_a), .mem_addr(addr_a),
      .t_out(t_a), .t_valid(tv_a), .sync_out(sy_a), .busy(bz_a), .done(dn_a)
   );

   mod_dds_seq #(.AW(8), .BT(4), .MEM_LAT(2)) dut_b (
      .clk(clk), .rstn(rstn), .s_axis(ifb), .abort(abort_b), .mem_addr(addr_b),
      .t_out(t_b), .t_valid(tv_b), .sync_out(sy_b), .busy(bz_b), .done(dn_b)
   );

   typedef struct {
      logic        tv;
      logic [24:0] td;
      logic        ab;
      logic        rdy;
      logic [7:0]  addr;
      logic        ov;
      logic [7:0]  t;
      logic        sy;
      logic        dn;
      logic        bz;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [24:0] cmd(input logic s, input logic [15:0] n, input logic [7:0] a);
      return {s, n, a};
   endfunction

   function automatic void add(input logic tv, input logic [24:0] td, input logic ab,
                               input logic rdy, input logic [7:0] addr, input logic ov,
                               input logic [7:0] t, input logic sy, input logic dn, input logic bz);
      vec_t v;
      v.tv = tv; v.td = td; v.ab = ab; v.rdy = rdy; v.addr = addr;
      v.ov = ov; v.t = t; v.sy = sy; v.dn = dn; v.bz = bz;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   initial begin
      int k;
      int n;

      // tv td ab | tready addr t_valid t sync done busy
      // single command, addr 0x12, 4 samples, sync
      add(1, cmd(1, 4, 8'h12), 0,  1, 8'h00, 0, 0, 0, 0, 0);
      add(0, 0, 0,                 0, 8'h12, 0, 0, 0, 0, 1);
      add(0, 0, 0,                 0, 8'h12, 0, 0, 0, 0, 1);
      add(0, 0, 0,                 0, 8'h12, 1, 0, 1, 0, 1);
      add(0, 0, 0,                 1, 8'h12, 1, 1, 0, 0, 1);
      add(0, 0, 0,                 1, 8'h12, 1, 2, 0, 0, 1);
      add(0, 0, 0,                 1, 8'h12, 1, 3, 0, 1, 1);
      add(0, 0, 0,                 1, 8'h12, 0, 3, 0, 0, 0);
      // back-to-back: 3 samples @0x01 then 2 samples @0x02 held valid early
      add(1, cmd(0, 3, 8'h01), 0,  1, 8'h12, 0, 3, 0, 0, 0);
      add(1, cmd(0, 2, 8'h02), 0,  0, 8'h01, 0, 3, 0, 0, 1);
      add(1, cmd(0, 2, 8'h02), 0,  0, 8'h01, 0, 3, 0, 0, 1);
      add(1, cmd(0, 2, 8'h02), 0,  1, 8'h01, 1, 0, 0, 0, 1);
      add(0, 0, 0,                 0, 8'h02, 1, 1, 0, 0, 1);
      add(0, 0, 0,                 1, 8'h02, 1, 2, 0, 1, 1);
      add(0, 0, 0,                 1, 8'h02, 1, 0, 0, 0, 1);
      add(0, 0, 0,                 1, 8'h02, 1, 1, 0, 1, 1);
      add(0, 0, 0,                 1, 8'h02, 0, 1, 0, 0, 0);
      // zero-length command is swallowed
      add(1, cmd(0, 0, 8'h33), 0,  1, 8'h02, 0, 1, 0, 0, 0);
      add(0, 0, 0,                 1, 8'h02, 0, 1, 0, 0, 0);
      add(0, 0, 0,                 1, 8'h02, 0, 1, 0, 0, 0);
      // abort on sample t=3 of a 10-sample command, then abort blocks accept in IDLE
      add(1, cmd(0, 10, 8'h44), 0, 1, 8'h02, 0, 1, 0, 0, 0);
      add(0, 0, 0,                 0, 8'h44, 0, 1, 0, 0, 1);
      add(0, 0, 0,                 0, 8'h44, 0, 1, 0, 0, 1);
      add(0, 0, 0,                 0, 8'h44, 1, 0, 0, 0, 1);
      add(0, 0, 1,                 0, 8'h44, 1, 1, 0, 0, 1);
      add(0, 0, 0,                 1, 8'h44, 1, 2, 0, 0, 1);
      add(0, 0, 0,                 1, 8'h44, 0, 2, 0, 0, 0);
      add(1, cmd(0, 5, 8'h55), 1,  0, 8'h44, 0, 2, 0, 0, 0);
      add(0, 0, 0,                 1, 8'h44, 0, 2, 0, 0, 0);

      rstn = 1'b0;
      abort_a = 1'b0; abort_b = 1'b0;
      ifa.tvalid = 1'b0; ifa.tdata = '0;
      ifb.tvalid = 1'b0; ifb.tdata = '0;
      repeat (2) @(negedge clk);
      ifa.tvalid = 1'b1;
      #1;
      chk("rst tready",  32'(ifa.tready), 0);
      chk("rst mem_addr", 32'(addr_a), 0);
      chk("rst t_valid", 32'(tv_a), 0);
      chk("rst t_out",   32'(t_a), 0);
      chk("rst sync",    32'(sy_a), 0);
      chk("rst busy",    32'(bz_a), 0);
      chk("rst done",    32'(dn_a), 0);
      ifa.tvalid = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < vecs.size(); i++) begin
         ifa.tvalid = vecs[i].tv;
         ifa.tdata  = vecs[i].td;
         abort_a    = vecs[i].ab;
         @(negedge clk);
         chk($sformatf("row%0d tready", i),   32'(ifa.tready), 32'(vecs[i].rdy));
         chk($sformatf("row%0d mem_addr", i), 32'(addr_a),     32'(vecs[i].addr));
         chk($sformatf("row%0d t_valid", i),  32'(tv_a),       32'(vecs[i].ov));
         chk($sformatf("row%0d t_out", i),    32'(t_a),        32'(vecs[i].t));
         chk($sformatf("row%0d sync", i),     32'(sy_a),       32'(vecs[i].sy));
         chk($sformatf("row%0d done", i),     32'(dn_a),       32'(vecs[i].dn));
         chk($sformatf("row%0d busy", i),     32'(bz_a),       32'(vecs[i].bz));
         @(posedge clk); #1;
      end
      ifa.tvalid = 1'b0;
      abort_a = 1'b0;

      // BT=4: time base saturates at 15 over a 20-sample command
      ifb.tvalid = 1'b1;
      ifb.tdata  = cmd(0, 20, 8'h09);
      @(negedge clk);
      chk("sat tready", 32'(ifb.tready), 1);
      @(posedge clk); #1;
      ifb.tvalid = 1'b0;
      k = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (tv_b) begin
            chk($sformatf("sat t_out[%0d]", k), 32'(t_b), (k > 15) ? 15 : k);
            chk($sformatf("sat done[%0d]", k), 32'(dn_b), (k == 19) ? 1 : 0);
            k++;
         end
      end
      chk("sat sample count", k, 20);
      chk("sat mem_addr", 32'(addr_b), 32'h09);
      chk("sat busy idle", 32'(bz_b), 0);

      // asynchronous reset while samples are in flight
      @(posedge clk); #1;
      ifa.tvalid = 1'b1;
      ifa.tdata  = cmd(1, 10, 8'h66);
      @(posedge clk); #1;
      ifa.tvalid = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk("pre-rst t_valid", 32'(tv_a), 1);
      chk("pre-rst mem_addr", 32'(addr_a), 32'h66);
      rstn = 1'b0;
      #1;
      chk("midrst tready",   32'(ifa.tready), 0);
      chk("midrst mem_addr", 32'(addr_a), 0);
      chk("midrst t_valid",  32'(tv_a), 0);
      chk("midrst t_out",    32'(t_a), 0);
      chk("midrst sync",     32'(sy_a), 0);
      chk("midrst busy",     32'(bz_a), 0);
      chk("midrst done",     32'(dn_a), 0);
      #3;
      rstn = 1'b1;
      @(posedge clk); #1;
      ifa.tvalid = 1'b1;
      ifa.tdata  = cmd(1, 1, 8'h07);
      @(negedge clk);
      chk("post-rst tready", 32'(ifa.tready), 1);
      @(posedge clk); #1;
      ifa.tvalid = 1'b0;
      n = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (tv_a) begin
            chk("post-rst t_out", 32'(t_a), 0);
            chk("post-rst done", 32'(dn_a), 1);
            chk("post-rst sync", 32'(sy_a), 1);
            n++;
         end
      end
      chk("post-rst sample count", n, 1);
      chk("post-rst mem_addr", 32'(addr_a), 32'h07);
      chk("post-rst busy idle", 32'(bz_a), 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
